// File: rtl/game_pkg.sv
// Shared game constants: top-level game states, grid action ops, grid geometry, serving cells.
// No logic; imported by the arbiter and its chop lock sub-module.
package game_pkg;

  localparam logic [2:0] GS_WELCOME = 3'd0;
  localparam logic [2:0] GS_START   = 3'd1;
  localparam logic [2:0] GS_PLAY    = 3'd2;
  localparam logic [2:0] GS_PAUSE   = 3'd3;
  localparam logic [2:0] GS_FINISH  = 3'd4;

  typedef enum logic [1:0] {
    OP_NONE   = 2'd0,
    OP_PICKUP = 2'd1,
    OP_DROP   = 2'd2,
    OP_CHOP   = 2'd3
  } op_e;

  localparam int GRID_ROWS = 8;
  localparam int GRID_COLS = 13;
  localparam int ROW_W     = $clog2(GRID_ROWS);
  localparam int COL_W     = $clog2(GRID_COLS);

  localparam logic [ROW_W-1:0] SERVE_ROW0 = ROW_W'(4);
  localparam logic [ROW_W-1:0] SERVE_ROW1 = ROW_W'(5);
  localparam logic [COL_W-1:0] SERVE_COL  = COL_W'(12);

endpackage

// File: rtl/chop_lock.sv
// Per-player chop lock: latches the chopped cell and holds it for CHOP_FRAMES PLAY frames.
// o_release is combinational so the arbiter sees an expiring or aborting lock as free this frame.
module chop_lock
  import game_pkg::*;
#(
  parameter int CHOP_FRAMES = 120
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic             i_freeze,
  input  logic [ROW_W-1:0] i_row,
  input  logic [COL_W-1:0] i_col,
  output logic             o_active,
  output logic             o_done,
  output logic             o_release,
  output logic [ROW_W-1:0] o_row,
  output logic [COL_W-1:0] o_col
);

  localparam int CW = (CHOP_FRAMES > 1) ? $clog2(CHOP_FRAMES) : 1;

  logic [CW-1:0]    r_cnt;
  logic             r_active;
  logic             r_done;
  logic [ROW_W-1:0] r_row;
  logic [COL_W-1:0] r_col;
  logic             w_expire;

  assign w_expire  = r_active && !i_freeze && !i_abort && (r_cnt == '0);
  assign o_release = r_active && !i_freeze && (i_abort || (r_cnt == '0));

  always_ff @(negedge clk) begin
    if (reset) begin
      r_cnt    <= '0;
      r_active <= 1'b0;
      r_done   <= 1'b0;
      r_row    <= '0;
      r_col    <= '0;
    end else begin
      // done reports a normal expiry even when the same player is re-granted a chop this frame
      r_done <= w_expire;
      if (i_start) begin
        r_active <= 1'b1;
        r_cnt    <= CW'(CHOP_FRAMES - 1);
        r_row    <= i_row;
        r_col    <= i_col;
      end else if (o_release) begin
        r_active <= 1'b0;
      end else if (r_active && !i_freeze) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  assign o_active = r_active;
  assign o_done   = r_done;
  assign o_row    = r_row;
  assign o_col    = r_col;

endmodule

// File: rtl/grid_action_arbiter.sv
// One grant per frame onto the grid update path: serving clears first, then players round-robin.
// Registered outputs at the sampling edge; ineligible requests simply stay pending until eligible.
module grid_action_arbiter
  import game_pkg::*;
#(
  parameter int NUM_PLAYERS = 4,
  parameter int CHOP_FRAMES = 120
) (
  input  logic                                vsync,
  input  logic                                reset,
  input  logic [2:0]                          game_state,
  input  logic [NUM_PLAYERS-1:0]              req,
  input  logic [NUM_PLAYERS-1:0][1:0]         req_op,
  input  logic [NUM_PLAYERS-1:0][ROW_W-1:0]   req_row,
  input  logic [NUM_PLAYERS-1:0][COL_W-1:0]   req_col,
  input  logic [1:0]                          clear_req,
  output logic [NUM_PLAYERS-1:0]              ack,
  output logic [1:0]                          clear_ack,
  output logic                                grant_valid,
  output logic                                grant_clear,
  output logic [1:0]                          grant_player,
  output logic [1:0]                          grant_op,
  output logic [ROW_W-1:0]                    grant_row,
  output logic [COL_W-1:0]                    grant_col,
  output logic [NUM_PLAYERS-1:0]              lock_active,
  output logic [NUM_PLAYERS-1:0]              chop_done
);

  logic                       w_play;
  logic                       w_pause;
  logic                       w_idle;
  logic [NUM_PLAYERS-1:0]     w_abort;
  logic [NUM_PLAYERS-1:0]     w_start;
  logic [NUM_PLAYERS-1:0]     w_lock_act;
  logic [NUM_PLAYERS-1:0]     w_lock_rel;
  logic [NUM_PLAYERS-1:0]     w_lock_done;
  logic [NUM_PLAYERS-1:0]     w_held;
  logic [NUM_PLAYERS-1:0][ROW_W-1:0] w_lock_row;
  logic [NUM_PLAYERS-1:0][COL_W-1:0] w_lock_col;
  logic [NUM_PLAYERS-1:0]     w_elig;
  logic                       w_found;
  logic [1:0]                 w_winner;
  logic [1:0]                 w_idx;

  logic [1:0]                 r_rr_ptr;
  logic [NUM_PLAYERS-1:0]     r_ack;
  logic [1:0]                 r_clear_ack;
  logic                       r_grant_valid;
  logic                       r_grant_clear;
  logic [1:0]                 r_grant_player;
  logic [1:0]                 r_grant_op;
  logic [ROW_W-1:0]           r_grant_row;
  logic [COL_W-1:0]           r_grant_col;

  assign w_play  = (game_state == GS_PLAY);
  assign w_pause = (game_state == GS_PAUSE);
  assign w_idle  = !w_play && !w_pause;

  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_lock
    // a lock survives only while its owner keeps asking to chop
    assign w_abort[g] = w_idle ||
                        (w_lock_act[g] && (!req[g] || (req_op[g] != OP_CHOP)));
    assign w_start[g] = w_play && (clear_req == 2'b00) && w_found &&
                        (w_winner == 2'(g)) && (req_op[g] == OP_CHOP);
    assign w_held[g]  = w_lock_act[g] && !w_lock_rel[g];

    chop_lock #(
      .CHOP_FRAMES(CHOP_FRAMES)
    ) u_chop_lock (
      .clk      (vsync),
      .reset    (reset),
      .i_start  (w_start[g]),
      .i_abort  (w_abort[g]),
      .i_freeze (w_pause),
      .i_row    (req_row[g]),
      .i_col    (req_col[g]),
      .o_active (w_lock_act[g]),
      .o_done   (w_lock_done[g]),
      .o_release(w_lock_rel[g]),
      .o_row    (w_lock_row[g]),
      .o_col    (w_lock_col[g])
    );
  end

  always_comb begin
    w_elig = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      w_elig[i] = req[i] && (req_op[i] != OP_NONE) &&
                  (req_col[i] <= COL_W'(GRID_COLS - 1)) && !w_held[i];
      for (int j = 0; j < NUM_PLAYERS; j++) begin
        if ((j != i) && w_held[j] && (w_lock_row[j] == req_row[i]) &&
            (w_lock_col[j] == req_col[i])) begin
          w_elig[i] = 1'b0;
        end
      end
    end
  end

  always_comb begin
    w_found  = 1'b0;
    w_winner = r_rr_ptr;
    w_idx    = r_rr_ptr;
    for (int k = 0; k < NUM_PLAYERS; k++) begin
      w_idx = r_rr_ptr + 2'(k);
      if (!w_found && w_elig[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  always_ff @(negedge vsync) begin
    if (reset) begin
      r_rr_ptr       <= '0;
      r_ack          <= '0;
      r_clear_ack    <= '0;
      r_grant_valid  <= 1'b0;
      r_grant_clear  <= 1'b0;
      r_grant_player <= '0;
      r_grant_op     <= '0;
      r_grant_row    <= '0;
      r_grant_col    <= '0;
    end else begin
      r_ack          <= '0;
      r_clear_ack    <= '0;
      r_grant_valid  <= 1'b0;
      r_grant_clear  <= 1'b0;
      r_grant_player <= '0;
      r_grant_op     <= '0;
      r_grant_row    <= '0;
      r_grant_col    <= '0;
      if (w_play) begin
        if (clear_req[0]) begin
          r_clear_ack   <= 2'b01;
          r_grant_valid <= 1'b1;
          r_grant_clear <= 1'b1;
          r_grant_row   <= SERVE_ROW0;
          r_grant_col   <= SERVE_COL;
        end else if (clear_req[1]) begin
          r_clear_ack   <= 2'b10;
          r_grant_valid <= 1'b1;
          r_grant_clear <= 1'b1;
          r_grant_row   <= SERVE_ROW1;
          r_grant_col   <= SERVE_COL;
        end else if (w_found) begin
          r_ack[w_winner] <= 1'b1;
          r_grant_valid   <= 1'b1;
          r_grant_player  <= w_winner;
          r_grant_op      <= req_op[w_winner];
          r_grant_row     <= req_row[w_winner];
          r_grant_col     <= req_col[w_winner];
          r_rr_ptr        <= w_winner + 2'd1;
        end
      end else if (!w_pause) begin
        r_rr_ptr <= '0;
      end
    end
  end

  assign ack          = r_ack;
  assign clear_ack    = r_clear_ack;
  assign grant_valid  = r_grant_valid;
  assign grant_clear  = r_grant_clear;
  assign grant_player = r_grant_player;
  assign grant_op     = r_grant_op;
  assign grant_row    = r_grant_row;
  assign grant_col    = r_grant_col;
  assign lock_active  = w_lock_act;
  assign chop_done    = w_lock_done;

endmodule

// File: doc/grid_action_arbiter.md
# grid_action_arbiter

Frame-rate arbiter that serialises the four players' grid actions (pickup, drop, chop) and the order logic's serving-counter clears onto the single object-grid update path. It sits between the player-state inputs and the grid action/update logic, gated by the top-level `game_state`. It issues at most one grant per frame: clears first, then players in round-robin order. It also holds multi-frame chop locks so that no other player can touch a cell while it is being chopped.

## Interface
Parameters:
- `NUM_PLAYERS`, default 4: number of requesters. Fixed at 4; the pointer is 2 bits.
- `CHOP_FRAMES`, default 120: length of a chop lock, in frames.

Ports:
- `vsync` in 1: the one clock. All state updates on the falling edge, matching the rest of the game logic.
- `reset` in 1: synchronous, active-high.
- `game_state` in 3: 0 WELCOME, 1 START, 2 PLAY, 3 PAUSE, 4 FINISH.
- `req` in [3:0]: per-player action request, level.
- `req_op` in [3:0][1:0]: 0 none, 1 pickup, 2 drop, 3 chop.
- `req_row` in [3:0][2:0]: target row, 0..7.
- `req_col` in [3:0][3:0]: target column, 0..12.
- `clear_req` in [1:0]: serving-cell clear. Bit0 targets row 4/col 12; bit1 targets row 5/col 12. Held high until acked.
- `ack` out [3:0]: one-frame pulse to the granted player.
- `clear_ack` out [1:0]: one-frame pulse for the granted clear.
- `grant_valid` out 1: a grant is issued this frame.
- `grant_clear` out 1: the current grant is a clear, not a player action.
- `grant_player` out 2: index of the granted player.
- `grant_op` out 2: operation of the granted player request.
- `grant_row` out 3: target row of the grant.
- `grant_col` out 4: target column of the grant.
- `lock_active` out [3:0]: per-player chop lock held.
- `chop_done` out [3:0]: one-frame pulse when a lock expires normally.

## Operation
Eligibility (player i):
- `req[i]`=1, `req_op[i]`≠0 and `req_col[i]`≤12.
- The player holds no lock.
- The target cell is not locked by any other player.
- Ineligible requests are never acked; they stay pending while `req` is high.

Arbitration on each PLAY frame:
- If any `clear_req` bit is high, grant the clear, bit0 before bit1.
  - `grant_clear`=1; row/col is the fixed serving cell; `grant_op`=0.
  - `rr_ptr` is unchanged.
- Otherwise grant the first eligible player scanning `rr_ptr`, `rr_ptr`+1, … mod 4. Then `rr_ptr` ← winner+1 mod 4.
- If no requester is eligible, `grant_valid`=0 and `rr_ptr` is unchanged.
- `req` is level-sensitive: a pickup/drop request still high after its ack is re-eligible on the next frame. Requesters drop `req` on `ack`.

Chop lock (per player):
- A granted chop loads the lock: row/col latched, counter = `CHOP_FRAMES`-1.
- The counter decrements each PLAY frame.
- At 0: lock clears and `chop_done[i]` pulses.
- If `req[i]` falls or `req_op[i]`≠3 during the lock, the lock clears immediately, with no `chop_done`.

Game-state gating:
- PAUSE: no grants; counters, locks and `rr_ptr` frozen.
- WELCOME, START, FINISH: no grants; all locks cleared without `chop_done`; `rr_ptr`←0.

Reset: every output 0, `rr_ptr`=0, all locks cleared.

## Timing
- Inputs are sampled at falling edge k. The grant outputs, `ack` and `clear_ack` are registered at edge k and hold until edge k+1. Latency is 0 frames after sampling.
- There is at most one grant per frame.
- Fairness bound: a continuously eligible player is granted within 4 player-grant frames when no clear is pending.
- Same-frame lock expiry and a new request to that cell: the expiry is applied first, so the request is eligible in that same frame.
- Two players requesting the same unlocked cell: only the round-robin winner is granted. The loser competes next frame and becomes ineligible if the winner's op was a chop.
- Lock counter width is `$clog2(CHOP_FRAMES)`. Entering PLAY→FINISH mid-chop clears the lock the same edge.

## Structure
- Package `game_pkg` holds:
  - `game_state` constants (WELCOME…FINISH).
  - The op enum (OP_NONE, OP_PICKUP, OP_DROP, OP_CHOP).
  - `GRID_ROWS`=8, `GRID_COLS`=13.
  - Serving-cell coordinates: row 4 and row 5, column 12.
- Sub-module `chop_lock`, instantiated ×4: counter plus latched row/col, with `start`/`abort`/`freeze` inputs and `active`/`done` outputs.
- The arbiter top holds the eligibility logic, the round-robin scan and the output registers.

## Test plan
- Reset, then PLAY with `req`=4'b1111, all ops pickup to distinct cells and `req` held → grants to players 0,1,2,3,0 on consecutive frames; `ack` one-hot each frame.
- `clear_req`=2'b11 while `req[2]` is high → frame 1 clear bit0 (row 4/col 12), frame 2 clear bit1 (row 5/col 12), frame 3 player 2. `rr_ptr` is unaffected by the clears.
- P1 chop at (3,5) with `CHOP_FRAMES`=4; P3 requests pickup at (3,5) → P3 is not acked while the lock is held; `chop_done[1]` pulses 4 PLAY frames after the grant; P3 is acked on that same frame.
- P0 chop locked; 2 frames in, `game_state`→PAUSE for 10 frames, then back to PLAY → no grants during PAUSE; the lock expires 2 PLAY frames after resume.
- P2 lock active; `req[2]` drops → `lock_active[2]`=0 next edge with no `chop_done`. Also `req_col`=13 is never acked.
- Mid-lock `game_state`→FINISH → locks cleared, `rr_ptr`=0, all outputs 0. Synchronous `reset` mid-grant zeroes all outputs at that edge.
